interval_timer_ctrl: RTL and testbench

//  Owns the programmable time-parameter registers and the countdown timer datapath of the traffic light controller.
//  The phase FSM requests an interval by code. This block loads the stored duration and counts it down on a

---
 rtl/interval_timer_ctrl_pkg.sv | 21 ++
 rtl/interval_timer_ctrl_if.sv | 37 +++
 rtl/interval_timer_ctrl_one_hz_divider.sv | 28 ++
 rtl/interval_timer_ctrl.sv | 112 +++++++++++
 tb/tb_interval_timer_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/interval_timer_ctrl_pkg.sv
// Shared interval codes, reset defaults and FSM encodings for the interval timer.
// No logic; no latency or backpressure of its own.
package interval_timer_ctrl_pkg;

   localparam logic [1:0] INT_BASE = 2'b00;
   localparam logic [1:0] INT_EXT  = 2'b01;
   localparam logic [1:0] INT_YEL  = 2'b10;
   localparam logic [1:0] INT_WALK = 2'b11;

   localparam int DEF_BASE = 6;
   localparam int DEF_EXT  = 3;
   localparam int DEF_YEL  = 2;
   localparam int DEF_WALK = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Phase-FSM / Reprogram side of the interval timer; master drives requests, slave is the timer.
// Optional TIMER_PAUSE_EN adds the hold level. No backpressure: all requests are single-cycle strobes.
interface interval_timer_ctrl_if #(
   parameter int PARAM_W = 4
);
   logic               Reprogram;
   logic [1:0]         Time_Parameter_Selector;
   logic [PARAM_W-1:0] Time_Value;
   logic               start_timer;
   logic [1:0]         interval;
   logic               oneHz_enable;
   logic [PARAM_W-1:0] value;
   logic               expired;
   logic               busy;
   logic               reprog_ack;
`ifdef TIMER_PAUSE_EN
   logic               hold;

   modport master (
      output Reprogram, Time_Parameter_Selector, Time_Value, start_timer, interval, hold,
      input  oneHz_enable, value, expired, busy, reprog_ack
   );
   modport slave (
      input  Reprogram, Time_Parameter_Selector, Time_Value, start_timer, interval, hold,
      output oneHz_enable, value, expired, busy, reprog_ack
   );
`else
   modport master (
      output Reprogram, Time_Parameter_Selector, Time_Value, start_timer, interval,
      input  oneHz_enable, value, expired, busy, reprog_ack
   );
   modport slave (
      input  Reprogram, Time_Parameter_Selector, Time_Value, start_timer, interval,
      output oneHz_enable, value, expired, busy, reprog_ack
   );
`endif
endinterface

// File: rtl/interval_timer_ctrl_one_hz_divider.sv
// Free-running 0..DIV_COUNT-1 divider; tick is combinational in the last count (0-cycle latency).
// enable=0 freezes the count and suppresses tick; clear wins over enable.
module one_hz_divider #(
   parameter int DIV_COUNT = 100_000_000
) (
   input  logic clk,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

   logic [CW-1:0] count;

   assign tick = enable && (count == LAST);

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/interval_timer_ctrl.sv
// Parameter registers plus countdown FSM; expired is registered, param*DIV_COUNT cycles after start.
// No backpressure; TIMER_PAUSE_EN adds hold, which freezes divider and count while high.
module interval_timer_ctrl #(
   parameter int DIV_COUNT = 100_000_000,
   parameter int PARAM_W   = 4,
   parameter int DEF_BASE  = interval_timer_ctrl_pkg::DEF_BASE,
   parameter int DEF_EXT   = interval_timer_ctrl_pkg::DEF_EXT,
   parameter int DEF_YEL   = interval_timer_ctrl_pkg::DEF_YEL,
   parameter int DEF_WALK  = interval_timer_ctrl_pkg::DEF_WALK
) (
   input logic                 clk,
   input logic                 Reset,
   interval_timer_ctrl_if.slave bus
);
   import interval_timer_ctrl_pkg::*;

   state_t             state, state_nxt;
   logic [PARAM_W-1:0] param [0:3];
   logic [PARAM_W-1:0] value, value_nxt;
   logic               expired, expired_nxt;
   logic               reprog_ack;
   logic               rp_q;
   logic               rp_edge;
   logic               start_ok;
   logic               run;
   logic               tick;
   logic               div_clear;

`ifdef TIMER_PAUSE_EN
   assign run = ~bus.hold;
`else
   assign run = 1'b1;
`endif

   assign rp_edge  = bus.Reprogram & ~rp_q;
   // A start arriving with a Reprogram edge is dropped, not deferred.
   assign start_ok = bus.start_timer & ~rp_edge;
   assign div_clear = rp_edge | start_ok;

   one_hz_divider #(.DIV_COUNT(DIV_COUNT)) u_div (
      .clk    (clk),
      .Reset  (Reset),
      .clear  (div_clear),
      .enable (run),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         param[INT_BASE] <= PARAM_W'(DEF_BASE);
         param[INT_EXT]  <= PARAM_W'(DEF_EXT);
         param[INT_YEL]  <= PARAM_W'(DEF_YEL);
         param[INT_WALK] <= PARAM_W'(DEF_WALK);
         rp_q            <= 1'b0;
         reprog_ack      <= 1'b0;
      end else begin
         rp_q       <= bus.Reprogram;
         reprog_ack <= rp_edge;
         if (rp_edge) begin
            param[bus.Time_Parameter_Selector] <=
               (bus.Time_Value == '0) ? PARAM_W'(1) : bus.Time_Value;
         end
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         value   <= '0;
         expired <= 1'b0;
      end else begin
         state   <= state_nxt;
         value   <= value_nxt;
         expired <= expired_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      value_nxt   = value;
      expired_nxt = 1'b0;
      if (rp_edge) begin
         state_nxt = ST_IDLE;
         value_nxt = '0;
      end else if (start_ok) begin
         state_nxt = ST_COUNT;
         value_nxt = param[bus.interval];
      end else begin
         case (state)
            ST_COUNT: begin
               if (tick) begin
                  if (value <= PARAM_W'(1)) begin
                     state_nxt   = ST_DONE;
                     value_nxt   = '0;
                     expired_nxt = 1'b1;
                  end else begin
                     value_nxt = value - 1'b1;
                  end
               end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bus.oneHz_enable = tick;
   assign bus.value        = value;
   assign bus.expired      = expired;
   assign bus.busy         = (state == ST_COUNT);
   assign bus.reprog_ack   = reprog_ack;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with DIV_COUNT=4; expected latencies are hand-computed.
module tb_interval_timer_ctrl;
   logic clk;
   logic Reset;
   int   vectors;
   int   errors;
   int   lat;
   int   cnt;

   interval_timer_ctrl_if #(.PARAM_W(4)) bus ();

   interval_timer_ctrl #(.DIV_COUNT(4), .PARAM_W(4)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Steps until expired is seen; returns cycles since the start edge, or max+1 on timeout.
   task automatic run_to_expire(input int max, output int n);
      n = max + 1;
      for (int i = 1; i <= max; i++) begin
         @(posedge clk);
         #1;
         if (bus.expired === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic start(input logic [1:0] code);
      bus.start_timer = 1'b1;
      bus.interval    = code;
      step(1);
      bus.start_timer = 1'b0;
   endtask

   task automatic reprog(input logic [1:0] sel, input logic [3:0] val);
      bus.Reprogram               = 1'b1;
      bus.Time_Parameter_Selector = sel;
      bus.Time_Value              = val;
      step(1);
      bus.Reprogram = 1'b0;
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      Reset   = 1'b1;
      bus.Reprogram = 1'b0;
      bus.Time_Parameter_Selector = 2'b00;
      bus.Time_Value  = 4'd0;
      bus.start_timer = 1'b0;
      bus.interval    = 2'b00;
`ifdef TIMER_PAUSE_EN
      bus.hold = 1'b0;
`endif
      step(3);
      chk("rst_value", bus.value, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_expired", bus.expired, 0);
      chk("rst_ack", bus.reprog_ack, 0);
      chk("rst_tick", bus.oneHz_enable, 0);
      Reset = 1'b0;
      step(2);

      // 1: base green, 6 seconds
      start(2'b00);
      chk("t1_load", bus.value, 6);
      chk("t1_busy", bus.busy, 1);
      step(3);
      chk("t1_tick_k3", bus.oneHz_enable, 1);
      chk("t1_val_k3", bus.value, 6);
      step(1);
      chk("t1_val_k4", bus.value, 5);
      run_to_expire(40, lat);
      chk("t1_latency", lat + 4, 24);
      chk("t1_busy_done", bus.busy, 0);
      chk("t1_val_done", bus.value, 0);
      step(1);
      chk("t1_exp_pulse", bus.expired, 0);
      chk("t1_idle_busy", bus.busy, 0);

      // 2: extension reprogrammed to 9, Reprogram held high for two cycles
      bus.Reprogram = 1'b1;
      bus.Time_Parameter_Selector = 2'b01;
      bus.Time_Value = 4'd9;
      step(1);
      chk("t2_ack", bus.reprog_ack, 1);
      step(1);
      chk("t2_ack_held", bus.reprog_ack, 0);
      bus.Reprogram = 1'b0;
      step(1);
      start(2'b01);
      chk("t2_load", bus.value, 9);
      run_to_expire(60, lat);
      chk("t2_latency", lat, 36);
      step(2);

      // 3: yellow written as 0 reads as 1
      reprog(2'b10, 4'd0);
      step(1);
      start(2'b10);
      chk("t3_load", bus.value, 1);
      run_to_expire(20, lat);
      chk("t3_latency", lat, 4);
      step(2);
      reprog(2'b10, 4'd2);
      step(1);

      // 4: restart mid-count with yellow
      start(2'b00);
      step(10);
      chk("t4_val_k10", bus.value, 4);
      start(2'b10);
      chk("t4_reload", bus.value, 2);
      run_to_expire(20, lat);
      chk("t4_latency", lat, 8);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (bus.expired === 1'b1) cnt++;
      end
      chk("t4_no_stale_exp", cnt, 0);

      // 5: Reprogram edge and start together while counting
      start(2'b00);
      step(5);
      bus.Reprogram = 1'b1;
      bus.Time_Parameter_Selector = 2'b11;
      bus.Time_Value = 4'd5;
      bus.start_timer = 1'b1;
      bus.interval = 2'b01;
      step(1);
      bus.start_timer = 1'b0;
      chk("t5_busy", bus.busy, 0);
      chk("t5_value", bus.value, 0);
      chk("t5_ack", bus.reprog_ack, 1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (bus.expired === 1'b1 || bus.busy === 1'b1) cnt++;
      end
      chk("t5_quiet", cnt, 0);
      bus.Reprogram = 1'b0;
      step(1);

      // 6: asynchronous reset mid-count
      start(2'b00);
      step(7);
      #2;
      Reset = 1'b1;
      #1;
      chk("t6_async_value", bus.value, 0);
      chk("t6_async_busy", bus.busy, 0);
      step(2);
      Reset = 1'b0;
      step(1);
      start(2'b11);
      chk("t6_walk_default", bus.value, 3);
      run_to_expire(30, lat);
      chk("t6_latency", lat, 12);
      step(2);
      start(2'b01);
      chk("t6_ext_default", bus.value, 3);
      run_to_expire(30, lat);
      chk("t6_ext_latency", lat, 12);
      step(2);

      // 7: restart on the final tick, then start from DONE
      start(2'b10);
      step(7);
      chk("t7_final_tick", bus.oneHz_enable, 1);
      start(2'b01);
      chk("t7_restart_val", bus.value, 3);
      chk("t7_restart_exp", bus.expired, 0);
      chk("t7_restart_busy", bus.busy, 1);
      run_to_expire(30, lat);
      chk("t7_latency", lat, 12);
      start(2'b10);
      chk("t7_done_start", bus.value, 2);
      chk("t7_done_busy", bus.busy, 1);
      run_to_expire(20, lat);
      chk("t7_done_latency", lat, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
